// File: rtl/flag_scheduler.sv
// flag_scheduler
//   Selects which of NUM_FLAGS test-pattern flags is shown. Steps on debounced
//   next/prev button presses or on a timed auto-advance, and inserts blanking
//   frames after every change. All state moves on frame_start only.
//
// Ports
//   clk          in   pixel clock
//   rst_n        in   async active-low reset
//   frame_start  in   1-cycle pulse at the first pixel of each frame
//   btn_next     in   raw async button, press steps forward
//   btn_prev     in   raw async button, press steps backward
//   auto_en      in   enables timed auto-advance
//   flag_sel     out  [3:0] registered active flag index
//   blank        out  registered, high while the pixel mux must drive black
//   changed      out  registered 1-cycle pulse on every flag_sel update
//
// state | meaning
// SHOW  | flag visible; counting dwell, accepting button events
// BLANK | output blanked for BLANK_FRAMES frames after a change
module flag_scheduler #(
    parameter int NUM_FLAGS       = 16,
    parameter int FRAMES_PER_FLAG = 300,
    parameter int BLANK_FRAMES    = 2,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_start,
    input  logic       btn_next,
    input  logic       btn_prev,
    input  logic       auto_en,
    output logic [3:0] flag_sel,
    output logic       blank,
    output logic       changed
);

    typedef enum logic {S_SHOW, S_BLANK} state_t;

    localparam logic [3:0] FLAG_LAST  = 4'(NUM_FLAGS - 1);
    localparam logic [9:0] DWELL_LAST = 10'(FRAMES_PER_FLAG - 1);
    localparam logic [3:0] BLANK_LAST = 4'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);
    localparam logic [1:0] DEB_MAX    = 2'(DEBOUNCE_FRAMES);

    // bit 0 = next button, bit 1 = prev button
    logic [1:0]      sync1_q, sync2_q;
    logic [1:0][1:0] stable_q, stable_d;
    logic [1:0]      armed_q, armed_d;
    logic [1:0]      pending_q, pending_d;
    logic [1:0]      press;

    state_t     state_q, state_d;
    logic [3:0] flag_sel_q, flag_sel_d;
    logic       blank_q, blank_d;
    logic       changed_q, changed_d;
    logic [9:0] frame_cnt_q, frame_cnt_d;
    logic [3:0] blank_cnt_q, blank_cnt_d;
    logic       step_fwd, step_back, clr_pend;

    assign flag_sel = flag_sel_q;
    assign blank    = blank_q;
    assign changed  = changed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            stable_q    <= '0;
            armed_q     <= '0;
            pending_q   <= '0;
            state_q     <= S_SHOW;
            flag_sel_q  <= '0;
            blank_q     <= 1'b0;
            changed_q   <= 1'b0;
            frame_cnt_q <= '0;
            blank_cnt_q <= '0;
        end else begin
            sync1_q     <= {btn_prev, btn_next};
            sync2_q     <= sync1_q;
            stable_q    <= stable_d;
            armed_q     <= armed_d;
            pending_q   <= pending_d;
            state_q     <= state_d;
            flag_sel_q  <= flag_sel_d;
            blank_q     <= blank_d;
            changed_q   <= changed_d;
            frame_cnt_q <= frame_cnt_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    // Debounce: a press fires once when the high count reaches DEB_MAX, and
    // the button must be seen low again (re-arm) before it can fire again.
    always_comb begin
        stable_d = stable_q;
        armed_d  = armed_q;
        press    = '0;
        if (frame_start) begin
            for (int b = 0; b < 2; b++) begin
                if (sync2_q[b]) begin
                    if (stable_q[b] != DEB_MAX) begin
                        stable_d[b] = stable_q[b] + 2'd1;
                    end
                    if (stable_d[b] == DEB_MAX && armed_q[b]) begin
                        press[b]   = 1'b1;
                        armed_d[b] = 1'b0;
                    end
                end else begin
                    stable_d[b] = '0;
                    armed_d[b]  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        flag_sel_d  = flag_sel_q;
        blank_d     = blank_q;
        changed_d   = 1'b0;
        frame_cnt_d = frame_cnt_q;
        blank_cnt_d = blank_cnt_q;
        step_fwd    = 1'b0;
        step_back   = 1'b0;
        clr_pend    = 1'b0;

        if (frame_start) begin
            unique case (state_q)
                S_SHOW: begin
                    if (pending_q == 2'b01) begin
                        step_fwd = 1'b1;
                    end else if (pending_q == 2'b10) begin
                        step_back = 1'b1;
                    end else if (pending_q == 2'b11) begin
                        clr_pend = 1'b1;
                    end else if (auto_en && frame_cnt_q == DWELL_LAST) begin
                        step_fwd = 1'b1;
                    end else begin
                        frame_cnt_d = auto_en ? frame_cnt_q + 10'd1 : 10'd0;
                    end
                end
                S_BLANK: begin
                    frame_cnt_d = '0;
                    if (blank_cnt_q == BLANK_LAST) begin
                        state_d  = S_SHOW;
                        blank_d  = 1'b0;
                        clr_pend = 1'b1;  // presses seen while blanked are dropped
                    end else begin
                        blank_cnt_d = blank_cnt_q + 4'd1;
                    end
                end
                default: state_d = S_SHOW;
            endcase
        end

        if (step_fwd) begin
            flag_sel_d = (flag_sel_q == FLAG_LAST) ? 4'd0 : flag_sel_q + 4'd1;
        end else if (step_back) begin
            flag_sel_d = (flag_sel_q == 4'd0) ? FLAG_LAST : flag_sel_q - 4'd1;
        end

        if (step_fwd || step_back) begin
            frame_cnt_d = '0;
            clr_pend    = 1'b1;
            changed_d   = 1'b1;
            if (BLANK_FRAMES > 0) begin
                blank_d     = 1'b1;
                blank_cnt_d = '0;
                state_d     = S_BLANK;
            end
        end

        // A press latched on the same frame as a clear survives it.
        pending_d = press | (pending_q & ~{2{clr_pend}});
    end

endmodule

// File: tb/tb_flag_scheduler.sv
module tb_flag_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       frame_start;
    logic       btn_next;
    logic       btn_prev;
    logic       auto_en;
    logic [3:0] flag_sel;
    logic       blank;
    logic       changed;

    int checks = 0;
    int errors = 0;
    int fs_count = 0;

    typedef struct {
        logic [3:0] flag;
        int         fs;
    } exp_t;

    exp_t sb_q[$];

    flag_scheduler #(
        .NUM_FLAGS(5),
        .FRAMES_PER_FLAG(4),
        .BLANK_FRAMES(2),
        .DEBOUNCE_FRAMES(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .frame_start(frame_start),
        .btn_next(btn_next),
        .btn_prev(btn_prev),
        .auto_en(auto_en),
        .flag_sel(flag_sel),
        .blank(blank),
        .changed(changed)
    );

    always #5 clk = ~clk;

    // Scoreboard consumer: every changed pulse must match the oldest expected step.
    always @(negedge clk) begin
        if (changed === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change: flag_sel=%0d at frame %0d, required no change", flag_sel, fs_count);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if (flag_sel !== e.flag || fs_count != e.fs) begin
                    errors++;
                    $display("FAIL step: flag_sel=%0d at frame %0d, required %0d at frame %0d",
                             flag_sel, fs_count, e.flag, e.fs);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic frame();
        repeat (3) @(negedge clk);
        frame_start = 1'b1;
        fs_count++;
        @(negedge clk);
        frame_start = 1'b0;
    endtask

    task automatic push(input logic [3:0] f, input int at_fs);
        exp_t e;
        e.flag = f;
        e.fs   = at_fs;
        sb_q.push_back(e);
    endtask

    task automatic check_flag(input string name, input logic [3:0] exp_f);
        checks++;
        if (flag_sel !== exp_f) begin
            errors++;
            $display("FAIL %s: flag_sel=%0d, required %0d", name, flag_sel, exp_f);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected steps never seen, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; frame_start = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; auto_en = 1'b0;
        #2;
        checks++;
        if (flag_sel !== 4'd0 || blank !== 1'b0 || changed !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: flag_sel=%0d blank=%b changed=%b, required 0 0 0", flag_sel, blank, changed);
        end
        auto_en = 1'b1;
        repeat (5) frame();
        check_flag("frame_in_reset", 4'd0);
        checks++;
        if (blank !== 1'b0) begin
            errors++;
            $display("FAIL frame_in_reset_blank: blank=%b, required 0", blank);
        end
        auto_en = 1'b0;
        rst_n = 1'b1;
        frame();
        check_flag("after_reset", 4'd0);
    endtask

    task automatic test_auto_advance();
        int  base;
        logic exp_blank;
        base = fs_count;
        auto_en = 1'b1;
        for (int k = 0; k < 5; k++) push(4'((k + 1) % 5), base + 4 + 6 * k);
        for (int i = 1; i <= 30; i++) begin
            if (i == 29) auto_en = 1'b0;
            frame();
            exp_blank = (i >= 4) && (((i - 4) % 6) < 2);
            checks++;
            if (blank !== exp_blank) begin
                errors++;
                $display("FAIL auto_blank: frame %0d blank=%b, required %b", i, blank, exp_blank);
            end
        end
        check_flag("auto_wrap", 4'd0);
        check_drained("auto_steps");
    endtask

    task automatic test_prev_wrap();
        frame();
        btn_prev = 1'b1;
        push(4'd4, fs_count + 3);
        repeat (3) frame();
        check_flag("prev_wrap", 4'd4);
        repeat (20) frame();
        check_flag("prev_hold", 4'd4);
        btn_prev = 1'b0;
        frame();
        check_drained("prev_steps");
    endtask

    task automatic test_blank_discard();
        btn_prev = 1'b1;
        push(4'd3, fs_count + 3);
        repeat (2) frame();
        btn_next = 1'b1;
        frame();
        checks++;
        if (blank !== 1'b1) begin
            errors++;
            $display("FAIL blank_after_step: blank=%b, required 1", blank);
        end
        repeat (7) frame();
        check_flag("blank_discard", 4'd3);
        btn_next = 1'b0;
        btn_prev = 1'b0;
        frame();
        check_drained("discard_steps");
    endtask

    task automatic test_both_pressed();
        btn_next = 1'b1;
        btn_prev = 1'b1;
        repeat (5) frame();
        check_flag("both_pressed", 4'd3);
        checks++;
        if (blank !== 1'b0) begin
            errors++;
            $display("FAIL both_blank: blank=%b, required 0", blank);
        end
        btn_next = 1'b0;
        btn_prev = 1'b0;
        frame();
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            btn_next = 1'b1;
            repeat (2) @(negedge clk);
            btn_next = 1'b0;
            frame();
        end
        check_flag("bounce_in_frame", 4'd3);
        for (int i = 0; i < 4; i++) begin
            btn_next = 1'b1;
            frame();
            btn_next = 1'b0;
            frame();
        end
        check_flag("bounce_alternate", 4'd3);
        check_drained("bounce_steps");
    endtask

    task automatic test_reset_during_blank();
        btn_prev = 1'b1;
        push(4'd2, fs_count + 3);
        repeat (3) frame();
        checks++;
        if (flag_sel !== 4'd2 || blank !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: flag_sel=%0d blank=%b, required 2 1", flag_sel, blank);
        end
        #1;
        btn_next = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (flag_sel !== 4'd0 || blank !== 1'b0 || changed !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: flag_sel=%0d blank=%b changed=%b, required 0 0 0", flag_sel, blank, changed);
        end
        btn_prev = 1'b0;
        frame();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) frame();
        check_flag("held_through_reset", 4'd0);
        btn_next = 1'b0;
        frame();
        btn_next = 1'b1;
        push(4'd1, fs_count + 3);
        repeat (3) frame();
        check_flag("repress_after_reset", 4'd1);
        btn_next = 1'b0;
        repeat (3) frame();
        check_drained("reset_steps");
    endtask

    initial begin
        test_reset();
        test_auto_advance();
        test_prev_wrap();
        test_blank_discard();
        test_both_pressed();
        test_bounce();
        test_reset_during_blank();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_scheduler.md
FLAG_SCHEDULER -- requirements
Module: flag_scheduler

Interface
REQ-001 Parameter NUM_FLAGS, default 16, SHALL set the number of selectable flags (2..16).
REQ-002 Parameter FRAMES_PER_FLAG, default 300, SHALL set the auto-advance dwell in frames (1..1023).
REQ-003 Parameter BLANK_FRAMES, default 2, SHALL set the blanking frames inserted after each change (0..15).
REQ-004 Parameter DEBOUNCE_FRAMES, default 3, SHALL set the consecutive high frame samples needed for a press (1..3).
REQ-005 Port clk, input, 1: pixel clock; the block has exactly one clock.
REQ-006 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-007 Port frame_start, input, 1: one-cycle pulse at the first pixel of each frame.
REQ-008 Port btn_next, input, 1: asynchronous raw button; a press steps to the next flag.
REQ-009 Port btn_prev, input, 1: asynchronous raw button; a press steps to the previous flag.
REQ-010 Port auto_en, input, 1: synchronous level that enables timed auto-advance.
REQ-011 Port flag_sel, output, 4: registered index of the active flag.
REQ-012 Port blank, output, 1: registered level; when high, the pixel mux drives black.
REQ-013 Port changed, output, 1: registered one-cycle pulse on every flag_sel update.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer before any use.
REQ-015 Debounce is per button and sampled only on frame_start.
- Synchronized level high: stable counter increments, saturating at DEBOUNCE_FRAMES.
- Synchronized level low: stable counter clears and the armed bit sets.
REQ-016 When a stable counter reaches DEBOUNCE_FRAMES while armed, the block SHALL latch a pending event for that button and clear armed, giving one event per press regardless of hold time.
REQ-017 FSM states SHALL be SHOW and BLANK, and all state and output changes SHALL occur only on frame_start cycles, never mid-frame.
REQ-018 SHOW on frame_start, decided in priority order:
- Exactly one pending event: step flag_sel in that direction.
- Both pending events set: clear both and do not step.
- No event, auto_en=1, frame_cnt==FRAMES_PER_FLAG-1: step flag_sel forward.
- Otherwise: frame_cnt increments if auto_en=1, or clears to 0 if auto_en=0.
REQ-019 Step arithmetic SHALL wrap:
- Next from NUM_FLAGS-1 gives 0.
- Prev from 0 gives NUM_FLAGS-1.
- flag_sel never exceeds NUM_FLAGS-1.
REQ-020 On any step:
- frame_cnt clears to 0 and both pending events clear.
- changed pulses high for exactly that one cycle.
- If BLANK_FRAMES>0: blank goes 1, blank_cnt clears to 0 and the FSM enters BLANK.
- If BLANK_FRAMES=0: the FSM stays in SHOW.
REQ-021 BLANK on frame_start:
- If blank_cnt==BLANK_FRAMES-1: enter SHOW and drop blank to 0.
- Otherwise: increment blank_cnt.
- frame_cnt holds at 0 throughout BLANK.
REQ-022 Events that become pending during BLANK SHALL be discarded on BLANK exit, while debounce and armed tracking continue normally.
REQ-023 Press-to-change latency: the 2-cycle synchronizer, then DEBOUNCE_FRAMES frame_start samples, then the change on the next frame_start in SHOW.
REQ-024 A frame_start arriving while rst_n is low SHALL have no effect.

Reset
REQ-025 While rst_n=0, asynchronously and regardless of clk:
- flag_sel=0, blank=0, changed=0.
- FSM=SHOW; frame_cnt, blank_cnt and stable counters =0.
- Pending events cleared; armed bits cleared.
- Synchronizer flops =0.
REQ-026 Armed bits reset to 0 so that a button held through reset SHALL NOT generate a press until it is first seen released.

Verification (NUM_FLAGS=5, FRAMES_PER_FLAG=4, BLANK_FRAMES=2, DEBOUNCE_FRAMES=2)
REQ-027 Auto-advance with auto_en=1 and no buttons:
- Response: flag_sel 0 goes to 1 on the 4th frame_start, with changed pulsed once and blank high for exactly 2 frames.
- Response: the next step occurs 2+4 frame_starts later, and the sequence 4 goes to 0 wraps.
REQ-028 btn_prev released at one frame_start, then held across 2 frame_starts, with flag_sel=0:
- Response: flag_sel=4 on the following frame_start.
- Response: continued holding for 20 frames gives no further step.
REQ-029 btn_next and btn_prev pressed together: no step and no changed pulse; flag_sel unchanged.
REQ-030 btn_next bounced high/low within one frame, never high at 2 consecutive frame_starts: no step.
REQ-031 btn_next held through rst_n release: no step until released and re-pressed; rst_n asserted during BLANK gives immediate flag_sel=0, blank=0 without waiting for clk.
